sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter RD_WAIT, default 2: cycles ce_n/oe_n held low per read; legal 1..7.
REQ-002 Parameter WR_WAIT, default 2: cycles we_n held low per write; legal 1..7.
REQ-003 Parameter ROM_WP, default 1: 1 suppresses writes to addresses with bit 19 = 0 (ROM half).
REQ-004 Parameter STARVE_MAX, default 4: consecutive CPU grants with vid_req pending before video is forced.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cpu_req  in  1  CPU-side access request, level.
REQ-008 cpu_we  in  1  1 = write, 0 = read.
REQ-009 cpu_a  in  20  CPU physical byte address.
REQ-010 cpu_di  in  8  CPU write data.
REQ-011 cpu_do  out  8  CPU read data, registered.
REQ-012 cpu_ack  out  1  one-cycle completion pulse for CPU.
REQ-013 vid_req  in  1  screen fetch request, level, read-only.
REQ-014 vid_a  in  20  screen fetch address.
REQ-015 vid_do  out  8  screen read data, registered.
REQ-016 vid_ack  out  1  one-cycle completion pulse for screen.
REQ-017 sram_a  out  20  SRAM address, registered.
REQ-018 sram_dq_o  out  8  SRAM write data; sram_dq_oe  out  1  data bus drive enable; sram_dq_i  in  8  SRAM read data.
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes, registered.

Function
REQ-020 FSM states IDLE, RD, WSU (write setup), WR, TURN; all outputs registered.
REQ-021 IDLE: no request -> stay, strobes high, dq_oe 0; request -> latch address/data/direction/owner, load wait counter, go RD (read) or WSU (write).
REQ-022 Arbitration in IDLE: only one requester -> grant it; both -> CPU, unless starve counter = STARVE_MAX -> video.
REQ-023 Starve counter: +1 per CPU grant while vid_req = 1, saturates at STARVE_MAX, clears on any video grant.
REQ-024 RD: ce_n=0, oe_n=0 for RD_WAIT cycles; sram_dq_i captured at the end of the last RD cycle into owner's do register; -> TURN.
REQ-025 WSU: one cycle, ce_n=0, we_n=1, dq_oe=1, dq_o=latched data; -> WR.
REQ-026 WR: we_n=0 for WR_WAIT cycles, ce_n=0, dq_oe=1; -> TURN.
REQ-027 TURN: one cycle, oe_n=we_n=1; after write ce_n=0 and dq_oe=1 (data hold), after read ce_n=1 and dq_oe=0; owner's ack=1; -> IDLE.
REQ-028 Latency, request sampled in IDLE at cycle n: read ack at n+RD_WAIT+1; write ack at n+WR_WAIT+2; next grant earliest at ack cycle +1.
REQ-029 Requester holds req, address, data stable until ack and drops req on the edge ending the ack cycle; req still high in the following IDLE starts a new access.
REQ-030 Write with ROM_WP=1 and cpu_a[19]=0: full WSU/WR/TURN timing and cpu_ack kept, we_n stays 1, dq_oe stays 0.
REQ-031 cpu_do/vid_do change only on their owner's read capture; otherwise hold last value.
REQ-032 vid_we does not exist; video accesses are always reads.
REQ-033 sram_oe_n and sram_we_n are never both 0; dq_oe is never 1 while oe_n = 0.
REQ-034 Request changes outside IDLE are ignored until the next IDLE.

Reset
REQ-035 reset_n low, immediately and asynchronously: state IDLE; ce_n, oe_n, we_n = 1; dq_oe = 0; acks = 0; sram_a, dq_o, cpu_do, vid_do, starve counter, wait counter = 0.
REQ-036 Reset mid-access aborts the access with no ack; first grant is sampled on the first rising edge after reset_n rises.

Structure
REQ-037 Shared package z88_pkg holds the FSM state enum, SRAM_AW = 20, SRAM_DW = 8, and ROM_REGION_BIT = 19.
REQ-038 Single module with no sub-modules; wait and starve counters are inline, each 3 bits wide.

Verification
REQ-039 CPU read 0x80010, SRAM model returns 0x5A, defaults -> ce_n/oe_n low 2 cycles, cpu_ack at n+3, cpu_do=0x5A.
REQ-040 CPU write 0x80020 = 0xC3 -> we_n low exactly 2 cycles, dq_oe high through TURN, ack at n+4, model byte = 0xC3.
REQ-041 CPU write 0x00020 = 0xFF with ROM_WP=1 -> we_n never low, cpu_ack at n+4, model unchanged.
REQ-042 cpu_req and vid_req held high continuously -> grant order C,C,C,C,V repeating, vid_ack every 5th access.
REQ-043 reset_n pulsed low during RD cycle 1 -> strobes high and dq_oe 0 within the same cycle, no ack, clean read after release.
REQ-044 Throughout all scenarios, assertions check REQ-033 and single-cycle ack width.

Source files
------------

// File: rtl/z88_pkg.sv
// Shared types and constants for the Z88 SRAM arbiter.
// Holds the access FSM encoding and the SRAM geometry.
package z88_pkg;

  localparam int SRAM_AW        = 20;
  localparam int SRAM_DW        = 8;
  localparam int ROM_REGION_BIT = 19;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WSU  = 3'd2,
    S_WR   = 3'd3,
    S_TURN = 3'd4
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_arb.sv
// Two-port arbiter (CPU + screen fetch) onto one async 8-bit SRAM.
// All SRAM strobes and client outputs come straight from flops.
module sram_arb
  import z88_pkg::*;
#(
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2,
  parameter int ROM_WP     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [SRAM_AW-1:0] cpu_a,
  input  logic [SRAM_DW-1:0] cpu_di,
  output logic [SRAM_DW-1:0] cpu_do,
  output logic               cpu_ack,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_a,
  output logic [SRAM_DW-1:0] vid_do,
  output logic               vid_ack,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [2:0] RDW  = 3'(RD_WAIT);
  localparam logic [2:0] WRW  = 3'(WR_WAIT);
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t     state;
  state_t     nxt;
  owner_t     own_r;
  logic       wr_r;
  logic       blk_r;
  logic [2:0] wcnt;
  logic [2:0] starve;

  logic gnt_cpu;
  logic gnt_vid;
  logic take;
  logic new_blk;
  logic last;

  logic ce_n_d;
  logic oe_n_d;
  logic we_n_d;
  logic dq_oe_d;
  logic cpu_ack_d;
  logic vid_ack_d;

  // Video wins a tie only once the CPU has starved it long enough.
  always_comb begin
    gnt_cpu = cpu_req && (!vid_req || starve != SMAX);
    gnt_vid = vid_req && !gnt_cpu;
    take    = (state == S_IDLE) && (gnt_cpu || gnt_vid);
    new_blk = (ROM_WP != 0) && !cpu_a[ROM_REGION_BIT];
    last    = (wcnt == 3'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (gnt_cpu)      nxt = cpu_we ? S_WSU : S_RD;
        else if (gnt_vid) nxt = S_RD;
      end
      S_RD:    if (last) nxt = S_TURN;
      S_WSU:   nxt = S_WR;
      S_WR:    if (last) nxt = S_TURN;
      S_TURN:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered, then registered.
  always_comb begin
    ce_n_d    = !((nxt == S_RD) || (nxt == S_WSU) || (nxt == S_WR)
                  || ((nxt == S_TURN) && wr_r));
    oe_n_d    = (nxt != S_RD);
    we_n_d    = !((nxt == S_WR) && !blk_r);
    dq_oe_d   = ((nxt == S_WSU) && !new_blk)
              || (((nxt == S_WR) || ((nxt == S_TURN) && wr_r)) && !blk_r);
    cpu_ack_d = (nxt == S_TURN) && (own_r == OWN_CPU);
    vid_ack_d = (nxt == S_TURN) && (own_r == OWN_VID);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
    end else begin
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_dq_oe <= dq_oe_d;
      cpu_ack    <= cpu_ack_d;
      vid_ack    <= vid_ack_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_r     <= OWN_CPU;
      wr_r      <= 1'b0;
      blk_r     <= 1'b0;
      wcnt      <= 3'd0;
      sram_a    <= '0;
      sram_dq_o <= '0;
    end else if (take) begin
      own_r  <= gnt_cpu ? OWN_CPU : OWN_VID;
      wr_r   <= gnt_cpu && cpu_we;
      blk_r  <= gnt_cpu && cpu_we && new_blk;
      wcnt   <= (gnt_cpu && cpu_we) ? WRW : RDW;
      sram_a <= gnt_cpu ? cpu_a : vid_a;
      if (gnt_cpu && cpu_we) sram_dq_o <= cpu_di;
    end else if ((state == S_RD) || (state == S_WR)) begin
      wcnt <= wcnt - 3'd1;
    end
  end

  // Read data lands on the edge that closes the last RD cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_do <= '0;
      vid_do <= '0;
    end else if ((state == S_RD) && last) begin
      if (own_r == OWN_VID) vid_do <= sram_dq_i;
      else                  cpu_do <= sram_dq_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= 3'd0;
    end else if (take) begin
      if (gnt_vid)
        starve <= 3'd0;
      else if (vid_req && (starve != SMAX))
        starve <= starve + 3'd1;
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: directed timing cases plus random two-client traffic
// against a byte-array SRAM model and a reference memory.
module tb_sram_arb;

  localparam int RD_WAIT    = 2;
  localparam int WR_WAIT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [19:0] cpu_a = '0;
  logic [7:0]  cpu_di = '0;
  logic [7:0]  cpu_do;
  logic        cpu_ack;
  logic        vid_req = 1'b0;
  logic [19:0] vid_a = '0;
  logic [7:0]  vid_do;
  logic        vid_ack;
  logic [19:0] sram_a;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i = '0;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  sram_arb #(
    .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT),
    .ROM_WP(1), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_a(vid_a), .vid_do(vid_do),
    .vid_ack(vid_ack), .sram_a(sram_a), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_fall = 0;
  int starve_seen = 0;
  logic pce = 1'b1;
  logic pc_ack = 1'b0;
  logic pv_ack = 1'b0;

  logic [7:0] mem [logic [19:0]];
  logic [7:0] ref_mem [logic [19:0]];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) cyc++;

  // SRAM model plus bus invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("oe_we_both_low", 32'(!sram_oe_n && !sram_we_n), 0);
      check("dq_oe_in_read", 32'(sram_dq_oe && !sram_oe_n), 0);
      check("cpu_ack_width", 32'(cpu_ack && pc_ack), 0);
      check("vid_ack_width", 32'(vid_ack && pv_ack), 0);
      check("ack_overlap", 32'(cpu_ack && vid_ack), 0);
      if (!sram_ce_n && !sram_we_n && sram_dq_oe)
        mem[sram_a] = sram_dq_o;
      if (!sram_ce_n && pce) ce_fall = cyc;
      if (cpu_ack && vid_req) starve_seen++;
      if (vid_ack) begin
        check("vid_starved", 32'(starve_seen <= STARVE_MAX + 1), 1);
        starve_seen = 0;
      end else if (!vid_req) begin
        starve_seen = 0;
      end
    end
    pce = sram_ce_n;
    pc_ack = cpu_ack;
    pv_ack = vid_ack;
    sram_dq_i = mem.exists(sram_a) ? mem[sram_a] : 8'h00;
  end

  task automatic cpu_txn(input logic we, input logic [19:0] a,
                         input logic [7:0] d, output int lat,
                         output int rlow, output int wlow,
                         output int dqcnt, output int dqhold);
    int n;
    bit ok;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_di = d;
    n = cyc; lat = -1; rlow = 0; wlow = 0; dqcnt = 0; dqhold = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!sram_ce_n && !sram_oe_n) rlow++;
      if (!sram_we_n) wlow++;
      if (sram_dq_oe) dqcnt++;
      if (cpu_ack) begin
        lat = cyc - n;
        dqhold = int'(sram_dq_oe);
        ok = 1;
        break;
      end
    end
    if (!ok) check("cpu_txn_timeout", 0, 1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic cpu_proc(input int cnt);
    logic [19:0] a;
    logic [7:0] d;
    logic we;
    bit ok;
    int idle;
    @(posedge clk);
    #1;
    for (int k = 0; k < cnt; k++) begin
      a = {1'($urandom), 15'd0, 4'($urandom)};
      d = 8'($urandom);
      we = 1'($urandom);
      cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_di = d;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (cpu_ack) begin ok = 1; break; end
      end
      if (!ok) begin
        check("cpu_rand_timeout", 0, 1);
      end else if (we) begin
        check("cpu_wr_latency", cyc - ce_fall, WR_WAIT + 1);
        if (a[19]) ref_mem[a] = d;
      end else begin
        check("cpu_rd_latency", cyc - ce_fall, RD_WAIT);
        check("cpu_rd_data", cpu_do, ref_rd(a));
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      idle = $urandom_range(0, 3);
      if (idle > 0) begin
        repeat (idle) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic vid_proc(input int cnt);
    logic [19:0] a;
    bit ok;
    int idle;
    @(posedge clk);
    #1;
    for (int k = 0; k < cnt; k++) begin
      a = {1'($urandom), 15'd0, 4'($urandom)};
      vid_req = 1'b1; vid_a = a;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (vid_ack) begin ok = 1; break; end
      end
      if (!ok) begin
        check("vid_rand_timeout", 0, 1);
      end else begin
        check("vid_rd_latency", cyc - ce_fall, RD_WAIT);
        check("vid_rd_data", vid_do, ref_rd(a));
      end
      @(posedge clk);
      #1;
      vid_req = 1'b0;
      idle = $urandom_range(0, 4);
      if (idle > 0) begin
        repeat (idle) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int lat, rlow, wlow, dqcnt, dqhold;
    int got_n;
    logic [19:0] pa;
    logic [7:0] pv;

    for (int i = 0; i < 32; i++) begin
      pa = {i[4], 15'd0, i[3:0]};
      pv = 8'($urandom);
      mem[pa] = pv;
      ref_mem[pa] = pv;
    end
    mem[20'h80010] = 8'h5A; ref_mem[20'h80010] = 8'h5A;
    mem[20'h80030] = 8'h3C; ref_mem[20'h80030] = 8'h3C;
    mem[20'h00020] = 8'h11; ref_mem[20'h00020] = 8'h11;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_acks", {cpu_ack, vid_ack}, 0);
    check("rst_sram_a", sram_a, 0);
    check("rst_dq_o", sram_dq_o, 0);
    check("rst_do", {cpu_do, vid_do}, 0);
    reset_n = 1'b1;

    cpu_txn(1'b0, 20'h80010, 8'h00, lat, rlow, wlow, dqcnt, dqhold);
    check("rd_latency", lat, RD_WAIT + 1);
    check("rd_strobe_cycles", rlow, RD_WAIT);
    check("rd_cpu_do", cpu_do, 8'h5A);

    cpu_txn(1'b1, 20'h80020, 8'hC3, lat, rlow, wlow, dqcnt, dqhold);
    check("wr_latency", lat, WR_WAIT + 2);
    check("wr_we_cycles", wlow, WR_WAIT);
    check("wr_dq_hold_turn", dqhold, 1);
    check("wr_mem", mem[20'h80020], 8'hC3);
    ref_mem[20'h80020] = 8'hC3;

    cpu_txn(1'b1, 20'h00020, 8'hFF, lat, rlow, wlow, dqcnt, dqhold);
    check("rom_latency", lat, WR_WAIT + 2);
    check("rom_we_cycles", wlow, 0);
    check("rom_dq_oe_cycles", dqcnt, 0);
    check("rom_mem", mem[20'h00020], 8'h11);

    // Abort a read in its first RD cycle.
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 20'h80010;
    @(posedge clk);
    #2;
    check("pre_abort_oe_n", sram_oe_n, 0);
    reset_n = 1'b0;
    #1;
    check("abort_ce_n", sram_ce_n, 1);
    check("abort_oe_n", sram_oe_n, 1);
    check("abort_dq_oe", sram_dq_oe, 0);
    check("abort_cpu_do", cpu_do, 0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    got_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) got_n++;
    end
    check("abort_no_ack", got_n, 0);
    cpu_txn(1'b0, 20'h80010, 8'h00, lat, rlow, wlow, dqcnt, dqhold);
    check("post_abort_latency", lat, RD_WAIT + 1);
    check("post_abort_do", cpu_do, 8'h5A);

    // Both clients saturate the bus: video every STARVE_MAX+1 grants.
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 20'h80010;
    vid_req = 1'b1; vid_a = 20'h80030;
    got_n = 0;
    for (int i = 0; i < 400 && got_n < 10; i++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) begin
        check("order_is_vid", vid_ack,
              32'((got_n % (STARVE_MAX + 1)) == STARVE_MAX));
        if (vid_ack) check("order_vid_do", vid_do, 8'h3C);
        got_n++;
      end
    end
    check("order_count", got_n, 10);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    repeat (2) @(posedge clk);

    fork
      cpu_proc(40);
      vid_proc(40);
    join
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
